// File: rtl/sample_frame_pkg.sv
// Shared types and register bit positions for the frame magnitude controller.
package sample_frame_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_VALID   = 2'd1,
      WAIT_RELEASE = 2'd2,
      DONE         = 2'd3
   } frame_state_t;

   typedef enum logic {
      MODE_SUM  = 1'b0,
      MODE_PEAK = 1'b1
   } mode_t;

   localparam int MCU_START = 0;
   localparam int MCU_CLEAR = 1;
   localparam int MCU_VALID = 2;
   localparam int MCU_ACK   = 3;
   localparam int MCU_MODE  = 4;

   localparam int ST_BUSY    = 0;
   localparam int ST_ARMED   = 2;
   localparam int ST_READY   = 3;
   localparam int ST_DONE    = 4;
   localparam int ST_OVERRUN = 5;

endpackage

// File: rtl/abs_accum.sv
// Two's-complement magnitude followed by a sum or running-max accumulator.
module abs_accum
   import sample_frame_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 23
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              enable,
   input  mode_t             mode,
   input  logic [DATA_W-1:0] sample,
   output logic [ACC_W-1:0]  acc
);

   logic [DATA_W-1:0] mag;
   logic [ACC_W-1:0]  mag_ext;
   logic [ACC_W-1:0]  acc_reg;
   logic [ACC_W-1:0]  acc_next;

   // Unsigned at DATA_W bits, so the most negative code becomes 2^(DATA_W-1).
   always_comb begin
      mag = sample;
      if (sample[DATA_W-1]) begin
         mag = ~sample + DATA_W'(1);
      end
   end

   always_comb begin
      mag_ext  = ACC_W'(mag);
      acc_next = acc_reg + mag_ext;
      if (mode == MODE_PEAK) begin
         acc_next = (mag_ext > acc_reg) ? mag_ext : acc_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_reg <= '0;
      end else if (clear) begin
         acc_reg <= '0;
      end else if (enable) begin
         acc_reg <= acc_next;
      end
   end

   assign acc = acc_reg;

endmodule

// File: rtl/sample_frame_ctrl.sv
// Frame collection FSM: four-phase sample handshake, per-frame magnitude
// statistic, result hold until acknowledge, sticky overrun flag.
module sample_frame_ctrl
   import sample_frame_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int FRAME_LEN = 128,
   parameter int ACC_W     = DATA_W + $clog2(FRAME_LEN)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        mcu_status,
   input  logic [DATA_W-1:0] sample_in,
   output logic [7:0]        asic_status,
   output logic [ACC_W-1:0]  result
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);

   frame_state_t     state_reg;
   frame_state_t     state_next;
   logic [7:0]       mcu_prev_reg;
   logic [CNT_W-1:0] count_reg;
   mode_t            mode_reg;
   logic [ACC_W-1:0] result_reg;
   logic             overrun_reg;
   logic [ACC_W-1:0] acc;
   logic [7:0]       status_bits;

   logic clear;
   logic start_rise;
   logic valid_lvl;
   logic valid_rise;
   logic ack_rise;
   logic start_accept;
   logic take_sample;
   logic enter_done;
   logic overrun_set;
   logic frame_full;
   logic unused_bits;

   assign clear      = mcu_status[MCU_CLEAR];
   assign valid_lvl  = mcu_status[MCU_VALID];
   assign start_rise = mcu_status[MCU_START] & ~mcu_prev_reg[MCU_START];
   assign valid_rise = mcu_status[MCU_VALID] & ~mcu_prev_reg[MCU_VALID];
   assign ack_rise   = mcu_status[MCU_ACK]   & ~mcu_prev_reg[MCU_ACK];
   assign frame_full = (count_reg == CNT_W'(FRAME_LEN));

   // Only start/valid/ack need a history; the rest of the copy is unused.
   assign unused_bits = ^{mcu_prev_reg[7:5], mcu_prev_reg[MCU_MODE], mcu_prev_reg[MCU_CLEAR]};

   always_comb begin
      state_next   = state_reg;
      start_accept = 1'b0;
      take_sample  = 1'b0;
      enter_done   = 1'b0;
      overrun_set  = 1'b0;
      if (clear) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_rise) begin
                  start_accept = 1'b1;
                  state_next   = WAIT_VALID;
               end
            end
            WAIT_VALID: begin
               // Level-sensitive: valid already high on arrival is a new sample.
               if (valid_lvl) begin
                  take_sample = 1'b1;
                  state_next  = WAIT_RELEASE;
               end
            end
            WAIT_RELEASE: begin
               if (!valid_lvl) begin
                  if (frame_full) begin
                     enter_done = 1'b1;
                     state_next = DONE;
                  end else begin
                     state_next = WAIT_VALID;
                  end
               end
            end
            DONE: begin
               if (valid_rise) begin
                  overrun_set = 1'b1;
               end
               if (ack_rise) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         mcu_prev_reg <= '0;
      end else begin
         state_reg    <= state_next;
         mcu_prev_reg <= mcu_status;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
         mode_reg  <= MODE_SUM;
      end else if (clear) begin
         count_reg <= '0;
      end else if (start_accept) begin
         count_reg <= '0;
         mode_reg  <= mode_t'(mcu_status[MCU_MODE]);
      end else if (take_sample) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   // acc already holds the last sample when WAIT_RELEASE exits to DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_reg  <= '0;
         overrun_reg <= 1'b0;
      end else if (clear) begin
         result_reg  <= '0;
         overrun_reg <= 1'b0;
      end else begin
         if (enter_done) begin
            result_reg <= acc;
         end
         if (overrun_set) begin
            overrun_reg <= 1'b1;
         end
      end
   end

   abs_accum #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_abs_accum (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear | start_accept),
      .enable (take_sample),
      .mode   (mode_reg),
      .sample (sample_in),
      .acc    (acc)
   );

   // Status decodes registered state only, so no input reaches an output combinationally.
   always_comb begin
      status_bits = '0;
      case (state_reg)
         WAIT_VALID: begin
            status_bits[ST_BUSY]  = 1'b1;
            status_bits[ST_ARMED] = 1'b1;
            status_bits[ST_READY] = 1'b1;
         end
         WAIT_RELEASE: begin
            status_bits[ST_BUSY]  = 1'b1;
            status_bits[ST_ARMED] = 1'b1;
         end
         DONE: begin
            status_bits[ST_DONE] = 1'b1;
         end
         default: ;
      endcase
      status_bits[ST_OVERRUN] = overrun_reg;
   end

   assign asic_status = status_bits;
   assign result      = result_reg;

endmodule

// File: tb/tb_sample_frame_ctrl.sv
// Directed bench: table of whole frames with hand-computed statistics, plus
// hand-written sequences for reset, overrun/clear and ignored inputs.
module tb_sample_frame_ctrl;

   localparam int DATA_W    = 16;
   localparam int FRAME_LEN = 128;
   localparam int ACC_W     = 23;

   logic              clk;
   logic              reset;
   logic [7:0]        mcu_status;
   logic [DATA_W-1:0] sample_in;
   logic [7:0]        asic_status;
   logic [ACC_W-1:0]  result;

   int n_cmp;
   int n_fail;

   typedef struct {
      string       name;
      logic        mode;
      logic [15:0] fill;
      int          ia;
      logic [15:0] va;
      int          ib;
      logic [15:0] vb;
      logic [22:0] exp_result;
   } frame_vec_t;

   frame_vec_t  vecs [9];
   logic [15:0] frame_buf [FRAME_LEN];

   sample_frame_ctrl #(
      .DATA_W    (DATA_W),
      .FRAME_LEN (FRAME_LEN),
      .ACC_W     (ACC_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mcu_status  (mcu_status),
      .sample_in   (sample_in),
      .asic_status (asic_status),
      .result      (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic mode);
      mcu_status[4] = mode;
      mcu_status[0] = 1'b1;
      tick();
      check("start_arm", {24'd0, asic_status}, 32'h0D);
      mcu_status[0] = 1'b0;
   endtask

   task automatic send_sample(input logic [15:0] v, input bit last);
      sample_in     = v;
      mcu_status[2] = 1'b1;
      tick();
      check("ready_fall", {24'd0, asic_status}, 32'h05);
      mcu_status[2] = 1'b0;
      tick();
      if (last) check("done_rise", {24'd0, asic_status}, 32'h10);
      else      check("ready_rise", {24'd0, asic_status}, 32'h0D);
   endtask

   task automatic ack_frame(input logic [7:0] exp_status);
      mcu_status[3] = 1'b1;
      tick();
      check("ack_idle", {24'd0, asic_status}, {24'd0, exp_status});
      mcu_status[3] = 1'b0;
      tick();
   endtask

   initial begin
      n_cmp      = 0;
      n_fail     = 0;
      reset      = 1'b1;
      mcu_status = 8'h00;
      sample_in  = '0;

      vecs[0] = '{"sum_ones",     1'b0, 16'h0001, -1,  16'h0000, -1,  16'h0000, 23'd128};
      vecs[1] = '{"peak_8000",    1'b1, 16'h0000, 77,  16'h8000, 100, 16'h7FFF, 23'd32768};
      vecs[2] = '{"sum_extreme",  1'b0, 16'h8000, -1,  16'h0000, -1,  16'h0000, 23'd4194304};
      vecs[3] = '{"sum_neg1",     1'b0, 16'hFFFF, -1,  16'h0000, -1,  16'h0000, 23'd128};
      vecs[4] = '{"peak_mixed",   1'b1, 16'h0005, 3,   16'hFF00, 50,  16'h0100, 23'd256};
      vecs[5] = '{"sum_edges",    1'b0, 16'h0000, 0,   16'h7FFF, 127, 16'h8001, 23'd65534};
      vecs[6] = '{"peak_zero",    1'b1, 16'h0000, -1,  16'h0000, -1,  16'h0000, 23'd0};
      vecs[7] = '{"sum_mixed",    1'b0, 16'h0002, 10,  16'hFFFE, -1,  16'h0000, 23'd256};
      vecs[8] = '{"peak_max_pos", 1'b1, 16'h0000, 5,   16'h8001, 6,   16'h7FFF, 23'd32767};

      // Reset values
      repeat (3) tick();
      check("reset_status", {24'd0, asic_status}, 32'h00);
      check("reset_result", {9'd0, result}, 32'd0);
      reset = 1'b0;
      tick();

      // Table-driven frames
      for (int v = 0; v < 9; v++) begin
         for (int i = 0; i < FRAME_LEN; i++) frame_buf[i] = vecs[v].fill;
         if (vecs[v].ia >= 0) frame_buf[vecs[v].ia] = vecs[v].va;
         if (vecs[v].ib >= 0) frame_buf[vecs[v].ib] = vecs[v].vb;
         start_frame(vecs[v].mode);
         for (int i = 0; i < FRAME_LEN; i++) send_sample(frame_buf[i], i == FRAME_LEN - 1);
         check(vecs[v].name, {9'd0, result}, {9'd0, vecs[v].exp_result});
         ack_frame(8'h00);
         $display("frame %s: result=%0d expected=%0d", vecs[v].name, result, vecs[v].exp_result);
      end

      // Reset mid-frame, then a fresh frame needs all 128 samples
      start_frame(1'b0);
      for (int i = 0; i < 5; i++) send_sample(16'h0001, 1'b0);
      reset = 1'b1;
      #1;
      check("midreset_status", {24'd0, asic_status}, 32'h00);
      check("midreset_result", {9'd0, result}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      start_frame(1'b0);
      for (int i = 0; i < FRAME_LEN; i++) send_sample(16'h0001, i == FRAME_LEN - 1);
      check("after_reset_sum", {9'd0, result}, 32'd128);
      ack_frame(8'h00);
      $display("reset mid-frame sequence done");

      // Overrun in DONE, survives ack, cleared by clear
      start_frame(1'b0);
      for (int i = 0; i < FRAME_LEN; i++) send_sample(16'h0003, i == FRAME_LEN - 1);
      check("overrun_frame_sum", {9'd0, result}, 32'd384);
      sample_in     = 16'h7FFF;
      mcu_status[2] = 1'b1;
      tick();
      check("overrun_set", {24'd0, asic_status}, 32'h30);
      check("overrun_result_held", {9'd0, result}, 32'd384);
      mcu_status[2] = 1'b0;
      tick();
      check("overrun_sticky_done", {24'd0, asic_status}, 32'h30);
      ack_frame(8'h20);
      mcu_status[1] = 1'b1;
      tick();
      check("clear_status", {24'd0, asic_status}, 32'h00);
      check("clear_result", {9'd0, result}, 32'd0);
      mcu_status[1] = 1'b0;
      tick();
      mcu_status[2] = 1'b1;
      tick();
      check("idle_valid_ignored", {24'd0, asic_status}, 32'h00);
      mcu_status[2] = 1'b0;
      tick();
      $display("overrun/clear sequence done");

      // Clear mid-frame drops the partial frame
      start_frame(1'b0);
      for (int i = 0; i < 3; i++) send_sample(16'h0004, 1'b0);
      mcu_status[1] = 1'b1;
      tick();
      check("clear_midframe", {24'd0, asic_status}, 32'h00);
      mcu_status[1] = 1'b0;
      tick();

      // Ignored start/ack mid-frame, mode flip mid-frame, start in DONE
      start_frame(1'b0);
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (i == 10) begin
            mcu_status[0] = 1'b1;
            tick();
            check("start_midframe_ignored", {24'd0, asic_status}, 32'h0D);
            mcu_status[0] = 1'b0;
            tick();
         end
         if (i == 20) begin
            mcu_status[3] = 1'b1;
            tick();
            check("ack_midframe_ignored", {24'd0, asic_status}, 32'h0D);
            mcu_status[3] = 1'b0;
            tick();
         end
         if (i == 64) mcu_status[4] = 1'b1;
         send_sample(16'h0002, i == FRAME_LEN - 1);
      end
      check("ignored_inputs_sum", {9'd0, result}, 32'd256);
      mcu_status[0] = 1'b1;
      tick();
      check("start_in_done_ignored", {24'd0, asic_status}, 32'h10);
      check("start_in_done_result", {9'd0, result}, 32'd256);
      mcu_status[0] = 1'b0;
      tick();
      ack_frame(8'h00);
      $display("ignored-inputs sequence done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_frame_ctrl.md
# sample_frame_ctrl

Parametrised successor to the single-sample MCU/ASIC control block. Collects a frame of `FRAME_LEN` signed samples from the MCU register bank using a four-phase valid/ready handshake carried in the status registers. Computes a per-frame magnitude statistic (sum or peak of |sample|) and presents it in the results register until the MCU acknowledges. Sits between the SPI register file and the DSP datapath, in the register-file clock domain.

## Interface
- `DATA_W`, 16, sample width in bits (two's complement).
- `FRAME_LEN`, 128, samples per frame; must be ≥ 2.
- `ACC_W`, `DATA_W + $clog2(FRAME_LEN)`, result width.
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mcu_status`  in  8  MCU control bits:
  - [0] start
  - [1] clear
  - [2] sample_valid
  - [3] result_ack
  - [4] mode (0 = sum |x|, 1 = peak |x|)
  - others ignored
- `sample_in`  in  DATA_W  sample value; must be stable while sample_valid is high.
- `asic_status`  out  8  status bits:
  - [0] busy
  - [2] armed
  - [3] ready
  - [4] frame_done
  - [5] overrun (sticky)
  - others 0
- `result`  out  ACC_W  frame statistic, zero-extended unsigned.

## Operation
- Inputs share the `clk` domain; no synchronisers. Edge detection uses one registered copy of `mcu_status`.
- States:
  - IDLE: busy=0, armed=0, ready=0. On start rising edge: latch mode, clear accumulator and counter, go to WAIT_VALID.
  - WAIT_VALID: busy=1, armed=1, ready=1. On sample_valid==1: capture `sample_in`, update accumulator, increment count, ready←0, go to WAIT_RELEASE.
  - WAIT_RELEASE: ready=0.
    - Stay while sample_valid==1.
    - When it reads 0: if count==FRAME_LEN go to DONE, else go to WAIT_VALID.
  - DONE: busy=0, armed=0, frame_done=1, `result` valid. On result_ack rising edge: frame_done←0, go to IDLE.
- Magnitude: |x| computed at DATA_W bits unsigned. The most negative input (e.g. 0x8000) maps to 32768 with no saturation.
- Sum mode: acc += |x|, ACC_W wide, cannot overflow by construction.
- Peak mode: acc = max(acc, |x|).
- `result` register is loaded from acc on entry to DONE and held until the next start. It reads 0 after reset.
- clear bit level-high, any state:
  - forces IDLE
  - zeroes acc, count, result and overrun
  - has priority over every other input that cycle
- Boundary cases:
  - start while busy or in DONE: ignored.
  - sample_valid high on arrival in WAIT_VALID: counts as a new sample. MCU must drop valid between samples.
  - sample_valid rising edge in IDLE: ignored, no flag.
  - sample_valid rising edge in DONE: sets overrun, sample discarded.
  - result_ack outside DONE: ignored.
  - mode changes mid-frame: no effect until the next start.
  - reset mid-frame: all state returns to reset values immediately, partial frame lost.
- Reset values: `asic_status` = 8'h00, `result` = 0, state IDLE, count 0, acc 0, registered mcu_status 0.

## Timing
- start edge seen at cycle N (registered compare) → armed=ready=1 from cycle N+1.
- sample_valid high sampled at cycle N → ready=0 at N+1. Sample is in acc at N+1.
- valid low sampled at cycle M → ready=1 at M+1, or frame_done=1 at M+1 on the last sample.
- Minimum per-sample period: 2 cycles (valid 1 cycle, low 1 cycle).
- result_ack edge at cycle N → frame_done=0, state IDLE at N+1. A new start is accepted from N+1.
- All outputs registered; no combinational paths from inputs to outputs.

## Structure
- Package `sample_frame_pkg`:
  - state enum `frame_state_t` {IDLE, WAIT_VALID, WAIT_RELEASE, DONE}
  - bit-index localparams for mcu_status and asic_status fields
  - mode enum {MODE_SUM, MODE_PEAK}
- Sub-module `abs_accum` (DATA_W, ACC_W): clear, enable and mode in; sign-magnitude conversion plus sum/max accumulate. The top holds the FSM, counter, edge detect and status/result registers.

## Test plan
- Reset mid-frame: after 5 samples assert reset for 1 cycle → asic_status=0x00, result=0. A fresh start then needs 128 new samples.
- Sum frame, FRAME_LEN=128, all samples 0x0001 in mode 0 → frame_done=1 and result=128. Every handshake shows ready falling 1 cycle after valid and rising 1 cycle after valid drops.
- Peak frame, mode 1: samples 0x0000…, one 0x8000 at index 77, one 0x7FFF at index 100 → result=32768.
- Extreme sum: 128 × 0x8000 in mode 0 → result=4194304 (23 bits, no wrap).
- Overrun and clear: in DONE pulse sample_valid → overrun=1, result unchanged. result_ack → IDLE with overrun still 1. Assert clear → asic_status=0x00.
- Ignored inputs: start pulsed mid-frame, result_ack pulsed in WAIT_VALID, mode flipped at sample 64 → count, mode and result unaffected. Frame completes normally after 128 samples.
